// File: rtl/ts_slot_scheduler_pkg.sv
// ts_slot_scheduler_pkg: shared state encodings and constants for the TS slot scheduler
package ts_slot_scheduler_pkg;
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ARB       = 4'd1;
  localparam logic [3:0] ST_WAIT_T2MI = 4'd2;
  localparam logic [3:0] ST_WAIT_TAB  = 4'd3;
  localparam logic [3:0] ST_WAIT_NULL = 4'd4;
  localparam int TS_PAYLOAD = 184;
  localparam logic [2:0] PEND_MAX = 3'd7;
endpackage

// File: rtl/ts_slot_scheduler_slot_nco.sv
// slot_nco: fractional phase accumulator producing a registered one-cycle slot tick on carry
module slot_nco #(
  parameter int ACC_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic [ACC_W-1:0] RATE_INC,
  output logic             tick
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + {1'b0, RATE_INC};
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      acc <= '0;
      tick <= 1'b0;
    end else begin
      acc <= ENABLE ? sum[ACC_W-1:0] : '0;
      tick <= ENABLE & sum[ACC_W];
    end
endmodule

// File: rtl/ts_slot_scheduler.sv
// ts_slot_scheduler: grants one 188-byte source (PSI table, T2-MI or null) per generated TS slot
module ts_slot_scheduler
  import ts_slot_scheduler_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int LVL_W   = 10,
  parameter int NUM_TAB = 3,
  parameter int INT_W   = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic [ACC_W-1:0]         RATE_INC,
  input  logic [LVL_W-1:0]         FIFO_LEVEL,
  input  logic [NUM_TAB*INT_W-1:0] TAB_INTERVAL,
  input  logic                     T2MI_DONE,
  input  logic                     TAB_DONE,
  input  logic                     NULL_DONE,
  output logic                     T2MI_START,
  output logic                     TAB_START,
  output logic                     NULL_START,
  output logic [1:0]               TAB_SEL,
  output logic                     BUSY,
  output logic [2:0]               PENDING,
  output logic                     SLOT_OVERRUN,
  output logic [3:0]               state_mon
);
  logic tick, tab_hit, grant, fifo_full;
  logic [3:0] state, next_state;
  logic [2:0] pending;
  logic [1:0] tab_idx;
  logic [NUM_TAB-1:0] due, tab_clr;

  slot_nco #(.ACC_W(ACC_W)) u_nco (
    .CLK(CLK),
    .RST(RST),
    .ENABLE(ENABLE),
    .RATE_INC(RATE_INC),
    .tick(tick)
  );

  always_comb begin
    tab_idx = '0;
    for (int i = NUM_TAB - 1; i >= 0; i--) tab_idx = due[i] ? 2'(i) : tab_idx;
  end

  assign tab_hit = |due;
  assign grant = state == ST_ARB && ENABLE;
  assign fifo_full = FIFO_LEVEL >= LVL_W'(TS_PAYLOAD);
  assign tab_clr = (grant && tab_hit) ? (NUM_TAB'(1) << tab_idx) : '0;

  // A tick and a grant in the same cycle cancel; a surplus tick at PEND_MAX is a lost slot.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      pending <= '0;
      SLOT_OVERRUN <= 1'b0;
    end else if (!ENABLE) pending <= '0;
    else if (tick && !grant) begin
      pending <= pending == PEND_MAX ? pending : pending + 3'd1;
      SLOT_OVERRUN <= SLOT_OVERRUN | (pending == PEND_MAX);
    end else if (grant && !tick) pending <= pending - 3'd1;

  for (genvar i = 0; i < NUM_TAB; i++) begin : g_tab
    logic [INT_W-1:0] cnt, iv;
    logic due_q;
    assign iv = TAB_INTERVAL[i*INT_W +: INT_W];
    assign due[i] = due_q;
    // Timer set wins over a same-cycle grant clear.
    always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
        cnt <= '0;
        due_q <= 1'b0;
      end else if (tick) begin
        cnt <= iv == '0 ? '0 : cnt == '0 ? iv - INT_W'(1) : cnt - INT_W'(1);
        due_q <= iv != '0 && (cnt == '0 || (due_q && !tab_clr[i]));
      end else if (tab_clr[i]) due_q <= 1'b0;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      next_state = ENABLE && pending != '0 ? ST_ARB : ST_IDLE;
      ST_ARB:       next_state = !ENABLE ? ST_IDLE : tab_hit ? ST_WAIT_TAB : fifo_full ? ST_WAIT_T2MI : ST_WAIT_NULL;
      ST_WAIT_T2MI: next_state = T2MI_DONE ? ST_IDLE : state;
      ST_WAIT_TAB:  next_state = TAB_DONE ? ST_IDLE : state;
      ST_WAIT_NULL: next_state = NULL_DONE ? ST_IDLE : state;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= ST_IDLE;
      T2MI_START <= 1'b0;
      TAB_START <= 1'b0;
      NULL_START <= 1'b0;
      TAB_SEL <= '0;
    end else begin
      state <= next_state;
      T2MI_START <= grant && !tab_hit && fifo_full;
      TAB_START <= grant && tab_hit;
      NULL_START <= grant && !tab_hit && !fifo_full;
      if (grant && tab_hit) TAB_SEL <= tab_idx;
    end

  assign BUSY = state == ST_WAIT_T2MI || state == ST_WAIT_TAB || state == ST_WAIT_NULL;
  assign PENDING = pending;
  assign state_mon = state;
endmodule

// File: tb/tb_ts_slot_scheduler.sv
// tb_ts_slot_scheduler: directed and randomized checks of ts_slot_scheduler against a slot-level reference model
module tb_ts_slot_scheduler;
  logic CLK = 0, RST = 0, ENABLE = 0;
  logic [31:0] RATE_INC = '0;
  logic [9:0] FIFO_LEVEL = '0;
  logic [47:0] TAB_INTERVAL = '0;
  logic T2MI_DONE = 0, TAB_DONE = 0, NULL_DONE = 0;
  logic T2MI_START, TAB_START, NULL_START, BUSY, SLOT_OVERRUN;
  logic [1:0] TAB_SEL;
  logic [2:0] PENDING;
  logic [3:0] state_mon;

  ts_slot_scheduler dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .RATE_INC(RATE_INC), .FIFO_LEVEL(FIFO_LEVEL),
    .TAB_INTERVAL(TAB_INTERVAL), .T2MI_DONE(T2MI_DONE), .TAB_DONE(TAB_DONE), .NULL_DONE(NULL_DONE),
    .T2MI_START(T2MI_START), .TAB_START(TAB_START), .NULL_START(NULL_START), .TAB_SEL(TAB_SEL),
    .BUSY(BUSY), .PENDING(PENDING), .SLOT_OVERRUN(SLOT_OVERRUN), .state_mon(state_mon)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int cyc = 0, done_at = -1, done_src = 0, dly = 1, spur_p = 0;
  bit rnd_dly = 0, rnd_en = 0;
  int n_st[3];
  int first_src = -1, first_sel = -1;

  // reference model: slots from phase arithmetic, table due-ness from tick count modulo interval
  int m_st, m_pend, m_sel, m_t;
  bit m_ts, m_tabs, m_ns, m_ovr, m_tick;
  bit m_due[3];
  longint unsigned k;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pend = 0; m_sel = 0; m_t = 0;
    m_ts = 0; m_tabs = 0; m_ns = 0; m_ovr = 0; m_tick = 0; k = 0;
    for (int i = 0; i < 3; i++) m_due[i] = 0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 3; i++) n_st[i] = 0;
    first_src = -1;
    first_sel = -1;
  endtask

  task automatic model_step();
    bit g, nt;
    int pick, iv, pend0;
    longint unsigned inc;
    inc = RATE_INC;
    g = m_st == 1 && ENABLE;
    pick = -1;
    for (int i = 0; i < 3; i++) if (m_due[i] && pick < 0) pick = i;
    nt = 0;
    if (ENABLE) begin
      k++;
      nt = ((k * inc) >> 32) != (((k - 1) * inc) >> 32);
    end else k = 0;
    if (m_tick) m_t++;
    for (int i = 0; i < 3; i++) begin
      iv = int'(TAB_INTERVAL[i*16 +: 16]);
      if (g && pick == i) m_due[i] = 0;
      if (m_tick) begin
        if (iv == 0) m_due[i] = 0;
        else if ((m_t - 1) % iv == 0) m_due[i] = 1;
      end
    end
    pend0 = m_pend;
    if (!ENABLE) m_pend = 0;
    else if (m_tick && !g) begin
      if (m_pend == 7) m_ovr = 1;
      else m_pend++;
    end else if (g && !m_tick) m_pend--;
    m_ts = 0; m_tabs = 0; m_ns = 0;
    case (m_st)
      0: if (ENABLE && pend0 > 0) m_st = 1;
      1: if (!g) m_st = 0;
         else if (pick >= 0) begin m_tabs = 1; m_sel = pick; m_st = 3; end
         else if (FIFO_LEVEL >= 184) begin m_ts = 1; m_st = 2; end
         else begin m_ns = 1; m_st = 4; end
      2: if (T2MI_DONE) m_st = 0;
      3: if (TAB_DONE) m_st = 0;
      4: if (NULL_DONE) m_st = 0;
      default: ;
    endcase
    m_tick = nt;
  endtask

  task automatic compare();
    check("t2mi_start", T2MI_START, m_ts);
    check("tab_start", TAB_START, m_tabs);
    check("null_start", NULL_START, m_ns);
    check("tab_sel", TAB_SEL, m_sel);
    check("busy", BUSY, m_st >= 2);
    check("pending", PENDING, m_pend);
    check("overrun", SLOT_OVERRUN, m_ovr);
    check("state", state_mon, m_st);
  endtask

  function automatic bit spur();
    return spur_p > 0 && $urandom_range(1, 8) <= spur_p;
  endfunction

  task automatic step();
    int src;
    @(negedge CLK);
    cyc++;
    model_step();
    compare();
    if (T2MI_START || TAB_START || NULL_START) begin
      src = T2MI_START ? 0 : TAB_START ? 1 : 2;
      n_st[src]++;
      if (first_src < 0) begin first_src = src; first_sel = TAB_SEL; end
      done_src = src;
      done_at = cyc + (rnd_dly ? int'($urandom_range(0, 6)) : dly);
    end
    T2MI_DONE = (done_at == cyc && done_src == 0) || (m_st != 2 && spur());
    TAB_DONE = (done_at == cyc && done_src == 1) || (m_st != 3 && spur());
    NULL_DONE = (done_at == cyc && done_src == 2) || (m_st != 4 && spur());
    if (rnd_en) begin
      if (ENABLE ? $urandom_range(0, 79) == 0 : $urandom_range(0, 9) == 0) ENABLE = !ENABLE;
      if ($urandom_range(0, 19) == 0) FIFO_LEVEL = 10'($urandom_range(170, 200));
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    RST = 0;
    T2MI_DONE = 0; TAB_DONE = 0; NULL_DONE = 0;
    done_at = -1;
    repeat (2) @(negedge CLK);
    model_reset();
    clear_stats();
    RST = 1;
  endtask

  task automatic check_zero();
    check("rst_t2mi_start", T2MI_START, 0);
    check("rst_tab_start", TAB_START, 0);
    check("rst_null_start", NULL_START, 0);
    check("rst_tab_sel", TAB_SEL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_pending", PENDING, 0);
    check("rst_overrun", SLOT_OVERRUN, 0);
    check("rst_state", state_mon, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_zero();
    model_reset();
    clear_stats();
    RST = 1;

    // constant T2-MI demand, slow return: pending climbs to saturation and overruns
    RATE_INC = 32'h4000_0000; FIFO_LEVEL = 200; TAB_INTERVAL = '0; dly = 5; ENABLE = 1;
    run(130);
    check("a_overrun", SLOT_OVERRUN, 1);
    check("a_pend_sat", PENDING, 7);
    check("a_only_t2mi", n_st[1] + n_st[2], 0);
    check("a_t2mi_seen", int'(n_st[0] > 10), 1);

    // just below one payload: nulls only; one payload: next grant is T2-MI
    FIFO_LEVEL = 183; clear_stats();
    run(60);
    check("b_no_t2mi", n_st[0], 0);
    check("b_nulls", int'(n_st[2] > 3), 1);
    FIFO_LEVEL = 184; clear_stats();
    for (int i = 0; i < 20 && first_src < 0; i++) step();
    check("b_184_t2mi", first_src, 0);

    // PSI tables ahead of T2-MI, lowest index first
    TAB_INTERVAL = {16'd3, 16'd2, 16'd1}; dly = 1; FIFO_LEVEL = 200;
    do_reset();
    run(160);
    check("c_first_tab", first_src, 1);
    check("c_first_sel", first_sel, 0);
    check("c_tabs_seen", int'(n_st[1] > 10), 1);

    // foreign DONEs during WAIT_TAB are ignored
    TAB_INTERVAL = {16'd0, 16'd0, 16'd1}; dly = 3; spur_p = 8;
    do_reset();
    for (int i = 0; i < 40 && m_st != 3; i++) step();
    check("d_in_wait_tab", state_mon, 3);
    run(2);
    check("d_still_wait_tab", state_mon, 3);
    run(2);
    check("d_idle_after_done", state_mon, 0);
    spur_p = 0;
    run(20);

    // ENABLE dropped in WAIT_T2MI: packet completes, nothing new is granted
    TAB_INTERVAL = '0; dly = 6; FIFO_LEVEL = 200;
    do_reset();
    for (int i = 0; i < 60 && m_st != 2; i++) step();
    check("e_in_wait_t2mi", state_mon, 2);
    ENABLE = 0; clear_stats();
    run(20);
    check("e_no_start", n_st[0] + n_st[1] + n_st[2], 0);
    check("e_idle", state_mon, 0);
    check("e_pend0", PENDING, 0);
    ENABLE = 1;
    run(40);
    check("e_resume", int'(n_st[0] > 0), 1);

    // asynchronous reset inside WAIT_NULL after an overrun
    RATE_INC = 32'h8000_0000; FIFO_LEVEL = 0; dly = 9;
    do_reset();
    run(60);
    check("f_ovr_before", SLOT_OVERRUN, 1);
    for (int i = 0; i < 40 && m_st != 4; i++) step();
    check("f_in_wait_null", state_mon, 4);
    #2 RST = 0;
    #1 check_zero();
    TAB_INTERVAL = {16'd0, 16'd0, 16'd2}; dly = 1;
    @(negedge CLK);
    model_reset();
    clear_stats();
    done_at = -1;
    T2MI_DONE = 0; TAB_DONE = 0; NULL_DONE = 0;
    RST = 1;
    run(40);
    check("f_first_tab", first_src, 1);
    check("f_first_sel", first_sel, 0);

    // randomized segments
    rnd_dly = 1; rnd_en = 1; spur_p = 2;
    for (int s = 0; s < 6; s++) begin
      RATE_INC = $urandom_range(32'h1555_0000, 32'h9000_0000);
      TAB_INTERVAL = {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))};
      FIFO_LEVEL = 10'($urandom_range(170, 200));
      ENABLE = 1;
      do_reset();
      run(500);
    end
    rnd_dly = 0; rnd_en = 0; spur_p = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
